// File: rtl/dma_read_responder.sv
// Read-side DMA responder: serves engine p2 (data) and p3 (weight) read ports from preloaded RAMs
// using a programmable address pattern (conv window, word repeat or linear wrap).
module dma_read_responder #(
  parameter int unsigned DW  = 16,
  parameter int unsigned DAW = 10,
  parameter int unsigned WAW = 8,
  parameter int unsigned CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic [1:0]     mode,
  input  logic [CW-1:0]  data_len,
  input  logic [CW-1:0]  win_len,
  input  logic [CW-1:0]  win_step,
  input  logic [CW-1:0]  rep_cnt,
  input  logic [CW-1:0]  wt_len,
  input  logic           load_we,
  input  logic           load_sel,
  input  logic [DAW-1:0] load_addr,
  input  logic [DW-1:0]  load_data,
  input  logic           dma_p2_reads_en,
  input  logic           dma_p3_reads_en,
  output logic [DW-1:0]  dma_p2_ob_data,
  output logic           dma_p2_ob_we,
  output logic [DW-1:0]  dma_p3_ob_data,
  output logic           dma_p3_ob_we,
  output logic           busy,
  output logic           addr_err,
  output logic [CW-1:0]  p2_served
);

  localparam int unsigned AW1 = DAW + 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e state_q;

  logic [DW-1:0] data_mem   [2**DAW];
  logic [DW-1:0] weight_mem [2**WAW];

  logic [1:0]    mode_q;
  logic [CW-1:0] data_len_q, win_len_q, win_step_q, rep_cnt_q, wt_len_q;

  logic [AW1-1:0] base_q, daddr_q;
  logic [WAW-1:0] waddr_q;
  logic [CW-1:0]  rcnt_q;

  logic [AW1-1:0] win_end, base_nxt, daddr_nxt, base_stepped;
  logic [CW-1:0]  rcnt_nxt;
  logic [WAW-1:0] waddr_nxt;

  assign busy = (state_q == StRun);

  // Next data/weight address, applied only when a request is accepted.
  always_comb begin
    win_end      = base_q + AW1'(win_len_q - CW'(1));
    base_stepped = base_q + AW1'(win_step_q);
    base_nxt     = base_q;
    daddr_nxt    = daddr_q + AW1'(1);
    rcnt_nxt     = rcnt_q;
    case (mode_q)
      2'd0: begin
        if (daddr_q == win_end) begin
          base_nxt  = base_stepped;
          daddr_nxt = base_stepped;
        end
      end
      2'd1: begin
        if (rcnt_q == rep_cnt_q) begin
          rcnt_nxt = '0;
        end else begin
          rcnt_nxt  = rcnt_q + CW'(1);
          daddr_nxt = daddr_q;
        end
      end
      default: begin
        if (32'(daddr_q) == 32'(data_len_q) - 32'd1) daddr_nxt = '0;
      end
    endcase
    waddr_nxt = (32'(waddr_q) == 32'(wt_len_q) - 32'd1) ? '0 : waddr_q + WAW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      dma_p2_ob_data <= '0;
      dma_p2_ob_we   <= 1'b0;
      dma_p3_ob_data <= '0;
      dma_p3_ob_we   <= 1'b0;
      addr_err       <= 1'b0;
      p2_served      <= '0;
      base_q         <= '0;
      daddr_q        <= '0;
      waddr_q        <= '0;
      rcnt_q         <= '0;
      mode_q         <= '0;
      data_len_q     <= CW'(1);
      win_len_q      <= CW'(1);
      win_step_q     <= '0;
      rep_cnt_q      <= '0;
      wt_len_q       <= CW'(1);
    end else begin
      dma_p2_ob_we <= 1'b0;
      dma_p3_ob_we <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            state_q    <= StRun;
            mode_q     <= mode;
            // Zero lengths behave as length one so the address stays put.
            data_len_q <= (data_len == '0) ? CW'(1) : data_len;
            win_len_q  <= (win_len == '0) ? CW'(1) : win_len;
            wt_len_q   <= (wt_len == '0) ? CW'(1) : wt_len;
            win_step_q <= win_step;
            rep_cnt_q  <= rep_cnt;
            base_q     <= '0;
            daddr_q    <= '0;
            waddr_q    <= '0;
            rcnt_q     <= '0;
            addr_err   <= 1'b0;
            p2_served  <= '0;
          end
        end
        StRun: begin
          if (dma_p2_reads_en) begin
            dma_p2_ob_we   <= 1'b1;
            dma_p2_ob_data <= data_mem[daddr_q[DAW-1:0]];
            if (daddr_q[DAW]) addr_err <= 1'b1;
            base_q  <= base_nxt;
            daddr_q <= daddr_nxt;
            rcnt_q  <= rcnt_nxt;
            if (p2_served != '1) p2_served <= p2_served + CW'(1);
          end
          if (dma_p3_reads_en) begin
            dma_p3_ob_we   <= 1'b1;
            dma_p3_ob_data <= weight_mem[waddr_q];
            waddr_q        <= waddr_nxt;
          end
          if (stop) state_q <= StIdle;
        end
      endcase
    end
  end

  // RAMs are writable only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_we && (state_q == StIdle)) begin
      if (!load_sel) data_mem[load_addr] <= load_data;
      else           weight_mem[load_addr[WAW-1:0]] <= load_data;
    end
  end

endmodule
